// File: rtl/key_debouncer.sv
// Multi-key debouncer with press, release and auto-repeat pulses.
// Each key runs an independent synchroniser + debounce/repeat FSM.
module key_debouncer #(
  parameter int KEY_NUM              = 4,
  parameter int ACTIVE_LOW           = 1,
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_NUM-1:0] keys_raw,
  output logic [KEY_NUM-1:0] pressed,
  output logic [KEY_NUM-1:0] press_pulse,
  output logic [KEY_NUM-1:0] release_pulse,
  output logic [KEY_NUM-1:0] repeat_pulse,
  output logic [KEY_NUM-1:0] step
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RD_W  = $clog2(REPEAT_DELAY_CYCLES + 1);
  localparam int RP_W  = $clog2(REPEAT_PERIOD_CYCLES + 1);
  localparam int RC_W0 = (RD_W > RP_W) ? RD_W : RP_W;
  localparam int RC_W  = (RC_W0 < 1) ? 1 : RC_W0;

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RC_W-1:0] RP_DLY  = RC_W'(REPEAT_DELAY_CYCLES);
  localparam logic [RC_W-1:0] RP_PER  = RC_W'(REPEAT_PERIOD_CYCLES);
  localparam logic            REP_EN  = (REPEAT_DELAY_CYCLES != 0);

  // Level the synchroniser holds when no key is pressed.
  localparam logic [KEY_NUM-1:0] RELEASED =
    (ACTIVE_LOW != 0) ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  logic [KEY_NUM-1:0] meta_q;
  logic [KEY_NUM-1:0] sync2_q;
  logic [KEY_NUM-1:0] sync;

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      meta_q  <= keys_raw;
      sync2_q <= meta_q;
    end
  end

  assign sync = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    state_e          state_q, state_d;
    logic [DB_W-1:0] db_q, db_d, db_inc;
    logic [RC_W-1:0] rc_q, rc_d, rc_inc, rc_tgt;
    logic            first_q, first_d;
    logic            prs_q, prs_d;
    logic            pp_q, pp_d;
    logic            rl_q, rl_d;
    logic            rp_q, rp_d;
    logic            st_q, st_d;

    assign db_inc = (db_q == {DB_W{1'b1}}) ? db_q : db_q + 1'b1;
    assign rc_inc = (rc_q == {RC_W{1'b1}}) ? rc_q : rc_q + 1'b1;
    assign rc_tgt = first_q ? RP_DLY : RP_PER;

    // Debounce/repeat next-state and next-pulse logic.
    always_comb begin
      state_d = state_q;
      db_d    = db_q;
      rc_d    = rc_q;
      first_d = first_q;
      prs_d   = prs_q;
      pp_d    = 1'b0;
      rl_d    = 1'b0;
      rp_d    = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync[i]) begin
            state_d = PRESS_WAIT;
            db_d    = DB_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync[i]) begin
            state_d = IDLE;
            db_d    = '0;
          end else if (db_inc >= DB_MAX) begin
            state_d = HELD;
            db_d    = '0;
            prs_d   = 1'b1;
            pp_d    = 1'b1;
            rc_d    = '0;
            first_d = 1'b1;
          end else begin
            db_d = db_inc;
          end
        end
        HELD: begin
          if (REP_EN) begin
            if (rc_inc >= rc_tgt) begin
              rp_d    = 1'b1;
              rc_d    = '0;
              first_d = 1'b0;
            end else begin
              rc_d = rc_inc;
            end
          end
          if (!sync[i]) begin
            state_d = RELEASE_WAIT;
            db_d    = DB_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync[i]) begin
            state_d = HELD;
            db_d    = '0;
          end else if (db_inc >= DB_MAX) begin
            state_d = IDLE;
            db_d    = '0;
            prs_d   = 1'b0;
            rl_d    = 1'b1;
          end else begin
            db_d = db_inc;
          end
        end
        default: state_d = IDLE;
      endcase
      st_d = pp_d | rp_d;
    end

    // Per-key state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        db_q    <= '0;
        rc_q    <= '0;
        first_q <= 1'b1;
        prs_q   <= 1'b0;
        pp_q    <= 1'b0;
        rl_q    <= 1'b0;
        rp_q    <= 1'b0;
        st_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        db_q    <= db_d;
        rc_q    <= rc_d;
        first_q <= first_d;
        prs_q   <= prs_d;
        pp_q    <= pp_d;
        rl_q    <= rl_d;
        rp_q    <= rp_d;
        st_q    <= st_d;
      end
    end

    assign pressed[i]       = prs_q;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rl_q;
    assign repeat_pulse[i]  = rp_q;
    assign step[i]          = st_q;
  end

endmodule
